// File: rtl/timer_bank.sv
// Bank of N_CH down-counting timers behind one MMIO window. Each channel counts
// PRESET down to 0, one-shot or auto-reload, and raises a sticky maskable pending flag.
module timer_bank #(
   parameter int N_CH     = 2,
   parameter int CH_W     = 1,
   parameter int PRESCALE = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CH_W+1:0]   addr,
   input  logic              we,
   input  logic [3:0]        byteen,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic [N_CH-1:0]   irq,
   output logic              irq_any
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
   localparam int SLOTS = 2 ** CH_W;

   typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

   logic [CH_W-1:0] sel;
   logic [1:0]      rsel;
   logic [31:0]     byte_mask;
   logic [31:0]     slot_rdata [SLOTS];

   assign sel  = addr[CH_W+1:2];
   assign rsel = addr[1:0];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_mask
         assign byte_mask[8*gi +: 8] = {8{byteen[gi]}};
      end

      // Decoder slots beyond N_CH read as zero and absorb writes.
      for (gi = 0; gi < SLOTS; gi++) begin : g_slot
         if (gi < N_CH) begin : g_ch
            state_t         state;
            logic [3:0]     ctrl;
            logic [31:0]    preset;
            logic [31:0]    count;
            logic           pending;
            logic [PW-1:0]  ps;
            logic           hit;
            logic           wr_ctrl;
            logic           wr_preset;
            logic           w1c;
            logic           set_pend;
            logic           auto_mode;
            logic [31:0]    preset_merged;

            assign hit           = we && (sel == CH_W'(gi));
            assign wr_ctrl       = hit && (rsel == 2'd0) && byteen[0];
            assign wr_preset     = hit && (rsel == 2'd1);
            assign w1c           = hit && (rsel == 2'd3) && byteen[0] && wdata[0];
            assign set_pend      = (state == CNT) && ctrl[0] && (count == 32'd0);
            assign auto_mode     = (ctrl[2:1] == 2'b01);
            assign preset_merged = (preset & ~byte_mask) | (wdata & byte_mask);

            always_ff @(posedge clk or posedge reset) begin
               if (reset) begin
                  state   <= IDLE;
                  ctrl    <= 4'd0;
                  preset  <= 32'd0;
                  count   <= 32'd0;
                  pending <= 1'b0;
                  ps      <= '0;
               end else begin
                  case (state)
                     IDLE: if (ctrl[0]) state <= LOAD;
                     LOAD: begin
                        count <= preset;
                        ps    <= '0;
                        state <= CNT;
                     end
                     CNT: begin
                        if (!ctrl[0]) begin
                           state <= IDLE;
                        end else if (count == 32'd0) begin
                           state <= INT;
                        end else if (ps == PS_LAST) begin
                           count <= count - 32'd1;
                           ps    <= '0;
                        end else begin
                           ps <= ps + 1'b1;
                        end
                     end
                     INT:     state <= auto_mode ? LOAD : IDLE;
                     default: state <= IDLE;
                  endcase

                  // A bus write to CTRL overrides the one-shot self-disable.
                  if (wr_ctrl)
                     ctrl <= wdata[3:0];
                  else if ((state == INT) && !auto_mode)
                     ctrl[0] <= 1'b0;

                  if (wr_preset)
                     preset <= preset_merged;

                  if (set_pend)
                     pending <= 1'b1;
                  else if (w1c)
                     pending <= 1'b0;
               end
            end

            assign slot_rdata[gi] = (rsel == 2'd0) ? {28'd0, ctrl} :
                                    (rsel == 2'd1) ? preset :
                                    (rsel == 2'd2) ? count :
                                                     {31'd0, pending};
            assign irq[gi] = pending & ctrl[3];
         end else begin : g_empty
            assign slot_rdata[gi] = 32'd0;
         end
      end
   endgenerate

   assign rdata   = slot_rdata[sel];
   assign irq_any = |irq;

endmodule

// File: tb/tb_timer_bank.sv
// Directed-plus-random bench for timer_bank: a PRESCALE=1 two-channel instance and a
// PRESCALE=4 three-channel instance, checked against arithmetic timing predictions.
module tb_timer_bank;
   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic [2:0]  a_addr;
   logic        a_we;
   logic [3:0]  a_be;
   logic [31:0] a_wdata;
   logic [31:0] a_rdata;
   logic [1:0]  a_irq;
   logic        a_any;

   logic [3:0]  b_addr;
   logic        b_we;
   logic [3:0]  b_be;
   logic [31:0] b_wdata;
   logic [31:0] b_rdata;
   logic [2:0]  b_irq;
   logic        b_any;

   int total = 0;
   int bad   = 0;

   timer_bank #(.N_CH(2), .CH_W(1), .PRESCALE(1)) dut_a (
      .clk(clk), .reset(reset), .addr(a_addr), .we(a_we), .byteen(a_be),
      .wdata(a_wdata), .rdata(a_rdata), .irq(a_irq), .irq_any(a_any)
   );

   timer_bank #(.N_CH(3), .CH_W(2), .PRESCALE(4)) dut_b (
      .clk(clk), .reset(reset), .addr(b_addr), .we(b_we), .byteen(b_be),
      .wdata(b_wdata), .rdata(b_rdata), .irq(b_irq), .irq_any(b_any)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Each write lands on the posedge after the next negedge; returns at the following negedge.
   task automatic wr_a(input int ch, input int r, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk);
      a_addr  = 3'((ch << 2) | r);
      a_wdata = d;
      a_be    = be;
      a_we    = 1'b1;
      @(negedge clk);
      a_we    = 1'b0;
      $display("wr A ch=%0d reg=%0d data=%h be=%b", ch, r, d, be);
   endtask

   task automatic wr_b(input int ch, input int r, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk);
      b_addr  = 4'((ch << 2) | r);
      b_wdata = d;
      b_be    = be;
      b_we    = 1'b1;
      @(negedge clk);
      b_we    = 1'b0;
      $display("wr B ch=%0d reg=%0d data=%h be=%b", ch, r, d, be);
   endtask

   task automatic rd_a(input int ch, input int r, output logic [31:0] d);
      a_addr = 3'((ch << 2) | r);
      #1;
      d = a_rdata;
   endtask

   task automatic rd_b(input int ch, input int r, output logic [31:0] d);
      b_addr = 4'((ch << 2) | r);
      #1;
      d = b_rdata;
   endtask

   initial begin
      int n, ch, p, q, j;
      logic [31:0] d, expv, old, nw;
      logic [3:0]  be, c;

      a_addr = '0; a_we = 1'b0; a_be = '0; a_wdata = '0;
      b_addr = '0; b_we = 1'b0; b_be = '0; b_wdata = '0;

      // Reset state
      repeat (2) @(negedge clk);
      rd_a(0, 0, d);
      check("reset_rdata", d, 32'd0);
      check("reset_irq_a", 32'(a_irq), 32'd0);
      check("reset_irq_any_b", 32'(b_any), 32'd0);
      reset = 1'b0;

      // One-shot: pending exactly N+3 edges after EN, EN self-clears, W1C drops irq
      for (int k = 0; k < 5; k++) begin
         ch = (k == 0) ? 0 : int'($urandom_range(0, 1));
         n  = (k == 0) ? 5 : int'($urandom_range(0, 8));
         c  = (k % 2 == 0) ? 4'h9 : 4'hD;
         wr_a(ch, 1, 32'(n), 4'hF);
         wr_a(ch, 0, 32'(c), 4'hF);
         for (int t = 1; t <= n + 3; t++) begin
            @(negedge clk);
            rd_a(ch, 2, d);
            expv = (t < 2 || t - 2 >= n) ? 32'd0 : 32'(n - (t - 2));
            check("oneshot_count", d, expv);
            check("oneshot_irq", 32'(a_irq[ch]), 32'(t == n + 3));
         end
         @(negedge clk);
         rd_a(ch, 0, d);
         check("oneshot_ctrl", d, 32'(c & 4'hE));
         wr_a(ch, 3, 32'd1, 4'h1);
         check("oneshot_clr_irq", 32'(a_irq), 32'd0);
         check("oneshot_clr_any", 32'(a_any), 32'd0);
      end

      // CTRL write landing on the one-shot INT edge wins over the self-disable
      wr_a(0, 1, 32'd3, 4'hF);
      wr_a(0, 0, 32'h9, 4'hF);
      repeat (5) @(negedge clk);
      wr_a(0, 0, 32'h9, 4'hF);
      rd_a(0, 0, d);
      check("ctrl_collision", d, 32'h9);
      check("ctrl_collision_irq", 32'(a_irq[0]), 32'd1);
      wr_a(0, 0, 32'h0, 4'hF);
      repeat (8) @(negedge clk);
      wr_a(0, 3, 32'd1, 4'h1);
      check("ctrl_collision_clr", 32'(a_irq), 32'd0);

      // Auto-reload: cleared every time, pending returns every N+3 cycles
      n = int'($urandom_range(1, 5));
      p = n + 3;
      wr_a(1, 1, 32'(n), 4'hF);
      wr_a(1, 0, 32'hB, 4'hF);
      a_addr = 3'((1 << 2) | 3); a_wdata = 32'd1; a_be = 4'h1;
      for (int t = 1; t <= 4 * p; t++) begin
         @(negedge clk);
         check("auto_irq", 32'(a_irq[1]), 32'(t % p == 0));
         a_we = (t % p == 0);
      end
      a_we = 1'b0;
      wr_a(1, 0, 32'h0, 4'hF);
      repeat (8) @(negedge clk);
      wr_a(1, 3, 32'd1, 4'h1);
      check("auto_clr", 32'(a_irq), 32'd0);

      // W1C on the very edge pending is re-set: set wins
      n = int'($urandom_range(1, 4));
      p = n + 3;
      wr_a(0, 1, 32'(n), 4'hF);
      wr_a(0, 0, 32'hB, 4'hF);
      a_addr = 3'(3); a_wdata = 32'd1; a_be = 4'h1;
      for (int t = 1; t <= 2 * p + 2; t++) begin
         @(negedge clk);
         check("w1c_collision_irq", 32'(a_irq[0]), 32'(t >= p));
         a_we = (t == 2 * p - 1);
      end
      a_we = 1'b0;
      rd_a(0, 3, d);
      check("w1c_collision_status", d, 32'd1);
      wr_a(0, 0, 32'h0, 4'hF);
      repeat (8) @(negedge clk);
      wr_a(0, 3, 32'd1, 4'h1);
      check("w1c_collision_clr", 32'(a_irq), 32'd0);

      // Byte-enable merge on PRESET
      wr_a(0, 1, 32'hFFFF_FFFF, 4'hF);
      wr_a(0, 1, 32'h0000_1200, 4'b0010);
      rd_a(0, 1, d);
      check("byte_merge_fixed", d, 32'hFFFF_12FF);
      for (int k = 0; k < 4; k++) begin
         old = $urandom;
         nw  = $urandom;
         be  = 4'($urandom_range(0, 15));
         wr_a(1, 1, old, 4'hF);
         wr_a(1, 1, nw, be);
         for (int b = 0; b < 4; b++)
            expv[8*b +: 8] = be[b] ? nw[8*b +: 8] : old[8*b +: 8];
         rd_a(1, 1, d);
         check("byte_merge_rand", d, expv);
      end
      wr_a(1, 0, 32'hFFFF_FFF0, 4'hF);
      rd_a(1, 0, d);
      check("ctrl_reserved", d, 32'd0);
      wr_a(1, 0, 32'hFFFF_FFFF, 4'hE);
      rd_a(1, 0, d);
      check("ctrl_byte0_off", d, 32'd0);

      // COUNT is read-only; channel N_CH absorbs writes and reads 0
      wr_b(2, 2, 32'h55, 4'hF);
      rd_b(2, 2, d);
      check("count_ro", d, 32'd0);
      wr_b(3, 1, 32'h7, 4'hF);
      wr_b(3, 0, 32'h9, 4'hF);
      repeat (6) @(negedge clk);
      for (int cch = 0; cch < 4; cch++)
         for (int r = 0; r < 4; r++) begin
            rd_b(cch, r, d);
            check("bad_channel_isolation", d, 32'd0);
         end
      check("bad_channel_irq", 32'(b_irq), 32'd0);

      // PRESCALE=4: pending after 4N+3 edges, masked irq, then IM exposes it
      for (int k = 0; k < 4; k++) begin
         ch = (k == 0) ? 0 : int'($urandom_range(0, 2));
         n  = (k == 0) ? 2 : int'($urandom_range(0, 3));
         p  = 4 * n + 3;
         wr_b(ch, 1, 32'(n), 4'hF);
         wr_b(ch, 0, 32'h1, 4'hF);
         for (int t = 1; t <= p; t++) begin
            @(negedge clk);
            rd_b(ch, 3, d);
            check("prescale_pending", d, 32'(t == p));
            rd_b(ch, 2, d);
            j = t - 2;
            q = (j < 0) ? 0 : j / 4;
            if (q > n) q = n;
            expv = (t < 2) ? 32'd0 : 32'(n - q);
            check("prescale_count", d, expv);
            check("prescale_irq_masked", 32'(b_irq), 32'd0);
         end
         wr_b(ch, 0, 32'h8, 4'hF);
         check("prescale_im_irq", 32'(b_irq[ch]), 32'd1);
         check("prescale_im_any", 32'(b_any), 32'd1);
         wr_b(ch, 3, 32'd1, 4'h1);
         check("prescale_clr", 32'(b_irq), 32'd0);
         wr_b(ch, 0, 32'h0, 4'hF);
      end

      // Asynchronous reset mid-count
      wr_a(1, 1, 32'd0, 4'hF);
      wr_a(1, 0, 32'h9, 4'hF);
      wr_a(0, 1, 32'd20, 4'hF);
      wr_a(0, 0, 32'h1, 4'hF);
      repeat (6) @(negedge clk);
      rd_a(0, 2, d);
      check("pre_reset_count", d, 32'd16);
      check("pre_reset_irq", 32'(a_irq), 32'd2);
      #1 reset = 1'b1;
      #1;
      check("async_reset_irq", 32'(a_irq), 32'd0);
      check("async_reset_any", 32'(a_any), 32'd0);
      check("async_reset_count", a_rdata, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int cch = 0; cch < 2; cch++)
         for (int r = 0; r < 4; r++) begin
            rd_a(cch, r, d);
            check("post_reset_read", d, 32'd0);
         end
      repeat (5) @(negedge clk);
      rd_a(0, 2, d);
      check("post_reset_no_restart", d, 32'd0);
      check("post_reset_irq", 32'(a_irq), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
